alu_ctrl: RTL and testbench

//  Command-driven initiator for the 8-bit combinational ALU: owns an 8x8 register file, sequences one

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_ctrl_if.sv | 39 +++
 rtl/alu_regfile.sv | 42 ++++
 rtl/alu_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, FSM state type and default widths for the ALU controller
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_W    = 8;
    localparam int ALU_NREG = 8;
    localparam int ALU_RW   = 3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op < OP_LOAD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_if.sv
// ============================================================================
// alu_ctrl_if : command / response handshake bundle between host and controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_ctrl_if
    import alu_pkg::*;
#(
    parameter int W  = ALU_W,
    parameter int RW = ALU_RW
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [RW-1:0] cmd_rd;
    logic [RW-1:0] cmd_rs1;
    logic [RW-1:0] cmd_rs2;
    logic [W-1:0]  cmd_imm;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_zero;
    logic          rsp_carry;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// alu_regfile : NREG x W register file, two async read ports, one sync write, r0 = 0
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_regfile
    import alu_pkg::*;
#(
    parameter int W    = ALU_W,
    parameter int NREG = ALU_NREG,
    parameter int RW   = ALU_RW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [RW-1:0] raddr_a_i,
    input  logic [RW-1:0] raddr_b_i,
    output logic [W-1:0]  rdata_a_o,
    output logic [W-1:0]  rdata_b_o
);

    logic [W-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/alu_ctrl.sv
// ============================================================================
// alu_ctrl : command-driven sequencer for an 8-bit combinational ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_ctrl
    import alu_pkg::*;
#(
    parameter int W    = ALU_W,
    parameter int NREG = ALU_NREG,
    parameter int RW   = ALU_RW
)(
    input  logic         clk,
    input  logic         rst_n,
    alu_ctrl_if.slave    bus,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_carry
);

    state_t        state_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [W-1:0]  rsp_data_q;
    logic          rsp_err_q;
    logic          zero_q;
    logic          carry_q;
    logic [W-1:0]  alu_a_q;
    logic [W-1:0]  alu_b_q;
    logic [3:0]    alu_opcode_q;
    logic [RW-1:0] rd_q;

    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  rf_rdata_a;
    logic [W-1:0]  rf_rdata_b;

    // Operands are read with the incoming command fields so they are already
    // registered on the ALU inputs for the whole EXEC cycle.
    alu_regfile #(.W(W), .NREG(NREG), .RW(RW)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (bus.cmd_rs1),
        .raddr_b_i (bus.cmd_rs2),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_result;
        if (state_q == ST_EXEC) begin
            rf_we = 1'b1;
        end else if (state_q == ST_IDLE && bus.cmd_valid && bus.cmd_op == OP_LOAD) begin
            rf_we    = 1'b1;
            rf_waddr = bus.cmd_rd;
            rf_wdata = bus.cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            rd_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        rd_q        <= bus.cmd_rd;
                        if (is_alu_op(bus.cmd_op)) begin
                            alu_a_q      <= rf_rdata_a;
                            alu_b_q      <= rf_rdata_b;
                            alu_opcode_q <= bus.cmd_op;
                            state_q      <= ST_EXEC;
                        end else begin
                            // LOAD and illegal ops skip the ALU entirely.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= (bus.cmd_op != OP_LOAD);
                            rsp_data_q  <= (bus.cmd_op == OP_LOAD) ? bus.cmd_imm : '0;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= alu_result;
                    zero_q      <= alu_zero;
                    carry_q     <= alu_carry;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_carry = carry_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_opcode    = alu_opcode_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ============================================================================
// tb_alu_ctrl : directed + random command stream against an arithmetic model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_opcode;
    logic       alu_zero, alu_carry;

    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry)
    );

    // Stand-in for the combinational ALU instance.
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_opcode)
            4'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = {alu_a[6:0], 1'b0};
            4'd6: alu_result = {1'b0, alu_a[7:1]};
            4'd7: alu_result = {7'd0, (alu_a == alu_b)};
            default: alu_result = 8'hA5;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    int vectors     = 0;
    int miscompares = 0;

    int mr [8];
    int mz, mc, mop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 0;
        mz = 0; mc = 0; mop = 0;
    endtask

    task automatic model_cmd(input int op, input int rd, input int rs1, input int rs2,
                             input int imm, output int d, output int err);
        int a, b, c;
        a = mr[rs1]; b = mr[rs2]; c = 0; d = 0; err = 0;
        case (op)
            0: begin d = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin d = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = (a * 2) % 256;
            6: d = a / 2;
            7: d = (a == b) ? 1 : 0;
            8: d = imm;
            default: err = 1;
        endcase
        if (op < 8) begin
            mz = (d == 0) ? 1 : 0;
            mc = c;
            mop = op;
        end
        if (op <= 8 && rd != 0) mr[rd] = d;
    endtask

    task automatic do_cmd(input int op, input int rd, input int rs1, input int rs2,
                          input int imm, input int hold);
        int n, ed, eerr, ea, eb;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        ea = mr[rs1]; eb = mr[rs2];
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op[3:0];
        bus.cmd_rd    = rd[2:0];
        bus.cmd_rs1   = rs1[2:0];
        bus.cmd_rs2   = rs2[2:0];
        bus.cmd_imm   = imm[7:0];
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 0);
        if (op < 8) begin
            chk("alu_a", 32'(alu_a), ea);
            chk("alu_b", 32'(alu_b), eb);
        end
        model_cmd(op, rd, rs1, rs2, imm, ed, eerr);
        n = 1;
        while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
        chk("latency", n, (op < 8) ? 2 : 1);
        chk("rsp_data", 32'(bus.rsp_data), ed);
        chk("rsp_err", 32'(bus.rsp_err), eerr);
        chk("rsp_zero", 32'(bus.rsp_zero), mz);
        chk("rsp_carry", 32'(bus.rsp_carry), mc);
        chk("alu_opcode", 32'(alu_opcode), mop);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                // Stray command during RESP must be ignored.
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_LOAD;
                bus.cmd_rd    = 3'd7;
                bus.cmd_imm   = 8'hAA;
            end
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 1);
            chk("hold_data", 32'(bus.rsp_data), ed);
            chk("hold_flags", {30'd0, bus.rsp_zero, bus.rsp_carry}, 32'((mz << 1) | mc));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 0);
        chk("cmd_ready_back", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_rd    = 3'd0;
        bus.cmd_rs1   = 3'd0;
        bus.cmd_rs2   = 3'd0;
        bus.cmd_imm   = 8'd0;
        bus.rsp_ready = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_all", {bus.rsp_data, bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 0);
        chk("rst_alu_drive", {alu_a, alu_b, alu_opcode}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(8, 1, 0, 0, 8'hF0, 0);
        do_cmd(8, 2, 0, 0, 8'h20, 0);
        do_cmd(0, 3, 1, 2, 0, 0);
        do_cmd(3, 0, 3, 0, 0, 0);
        do_cmd(8, 1, 0, 0, 8'h05, 0);
        do_cmd(8, 2, 0, 0, 8'h05, 0);
        do_cmd(1, 3, 1, 2, 0, 0);
        do_cmd(8, 1, 0, 0, 8'h01, 0);
        do_cmd(8, 2, 0, 0, 8'h02, 0);
        do_cmd(1, 1, 1, 2, 0, 0);
        do_cmd(12, 2, 1, 1, 0, 0);
        do_cmd(3, 0, 2, 0, 0, 0);
        do_cmd(0, 4, 1, 2, 0, 5);
        do_cmd(3, 0, 7, 0, 0, 0);
        do_cmd(8, 1, 0, 0, 8'h03, 0);
        do_cmd(8, 2, 0, 0, 8'h04, 0);
        do_cmd(0, 0, 1, 2, 0, 0);
        do_cmd(3, 0, 0, 0, 0, 0);
        do_cmd(8, 1, 0, 0, 8'h81, 0);
        do_cmd(5, 2, 1, 0, 0, 0);
        do_cmd(6, 2, 1, 0, 0, 0);
        do_cmd(0, 1, 1, 1, 0, 0);

        // Reset asserted while an ADD sits in EXEC.
        do_cmd(8, 1, 0, 0, 8'hFF, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_rd    = 3'd5;
        bus.cmd_rs1   = 3'd1;
        bus.cmd_rs2   = 3'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("exec_no_rsp", 32'(bus.rsp_valid), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("abort_flags", {30'd0, bus.rsp_zero, bus.rsp_carry}, 0);
        chk("abort_alu_drive", {alu_a, alu_b, alu_opcode}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_cmd(3, 0, 5, 0, 0, 0);
        do_cmd(3, 0, 1, 0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) op = int'($urandom_range(9, 15));
            else                           op = int'($urandom_range(0, 8));
            do_cmd(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
